// File: rtl/serial_deframer_pkg.sv
// Shared types and constants for the serial deframer.
package serial_deframer_pkg;

   localparam int unsigned LEN_W = 8;
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_LEN     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CHECK   = 2'd3
   } state_t;

endpackage

// File: rtl/serial_byte_window.sv
// LSB-first shift window with a 3-bit bit counter and a byte boundary strobe.
module serial_byte_window (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bit_in,
   input  logic       bit_valid,
   input  logic       clr_cnt,
   output logic [7:0] win_nxt_c,
   output logic       byte_done_c
);

   logic [7:0] win;
   logic [2:0] bit_cnt;

   // Window value after this cycle's bit; the caller decides on the updated byte.
   assign win_nxt_c   = {bit_in, win[7:1]};
   assign byte_done_c = bit_valid && (bit_cnt == 3'd7);

   // Shift and count only on valid bits; counter restarts when sync is found.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win     <= 8'd0;
         bit_cnt <= 3'd0;
      end else if (bit_valid) begin
         win <= win_nxt_c;
         if (clr_cnt) begin
            bit_cnt <= 3'd0;
         end else begin
            bit_cnt <= bit_cnt + 3'd1;
         end
      end
   end

endmodule

// File: rtl/serial_deframer.sv
// Sync-hunting frame parser: sync, length, payload, checksum; payload on valid/ready.
module serial_deframer
   import serial_deframer_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE,
   parameter int unsigned MAX_LEN   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bit_in,
   input  logic       bit_valid,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic       overflow,
   output logic       in_sync
);

   localparam logic [LEN_W-1:0] MAX_LEN_B = LEN_W'(MAX_LEN);

   state_t           state;
   logic [LEN_W-1:0] remaining;
   logic [7:0]       sum;
   logic             bad;

   logic [7:0]       byte_c;
   logic             byte_done_c;
   logic             sync_hit_c;

   // A sync match in HUNT also restarts byte alignment.
   assign sync_hit_c = (state == ST_HUNT) && (byte_c == SYNC_BYTE);

   serial_byte_window u_window (
      .clk         (clk),
      .rst_n       (rst_n),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .clr_cnt     (sync_hit_c),
      .win_nxt_c   (byte_c),
      .byte_done_c (byte_done_c)
   );

   // Frame FSM, running checksum and single-entry output register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_HUNT;
         remaining <= '0;
         sum       <= 8'd0;
         bad       <= 1'b0;
         out_data  <= 8'd0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
         in_sync   <= 1'b0;
      end else begin
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;

         // Accept frees the register; a same-cycle load below overrides this.
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end

         if (bit_valid) begin
            case (state)
               ST_HUNT: begin
                  if (sync_hit_c) begin
                     state   <= ST_LEN;
                     in_sync <= 1'b1;
                  end
               end
               ST_LEN: begin
                  if (byte_done_c) begin
                     if ((byte_c == 8'd0) || (byte_c > MAX_LEN_B)) begin
                        frame_err <= 1'b1;
                        in_sync   <= 1'b0;
                        state     <= ST_HUNT;
                     end else begin
                        remaining <= byte_c;
                        sum       <= 8'd0;
                        bad       <= 1'b0;
                        state     <= ST_PAYLOAD;
                     end
                  end
               end
               ST_PAYLOAD: begin
                  if (byte_done_c) begin
                     sum       <= sum + byte_c;
                     remaining <= remaining - LEN_W'(1);
                     if (!out_valid || out_ready) begin
                        out_data  <= byte_c;
                        out_valid <= 1'b1;
                        out_last  <= (remaining == LEN_W'(1));
                     end else begin
                        // Held byte is never retracted; the new one is lost.
                        overflow <= 1'b1;
                        bad      <= 1'b1;
                     end
                     if (remaining == LEN_W'(1)) begin
                        state <= ST_CHECK;
                     end
                  end
               end
               ST_CHECK: begin
                  if (byte_done_c) begin
                     if ((byte_c == sum) && !bad) begin
                        frame_ok <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                     in_sync <= 1'b0;
                     state   <= ST_HUNT;
                  end
               end
               default: begin
                  state   <= ST_HUNT;
                  in_sync <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_deframer.sv
// Scoreboard bench for serial_deframer: directed frames, monitor checks bytes and pulses.
module tb_serial_deframer;

   logic       clk;
   logic       rst_n;
   logic       bit_in;
   logic       bit_valid;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       frame_ok;
   logic       frame_err;
   logic       overflow;
   logic       in_sync;

   int n_vec = 0;
   int n_err = 0;

   // Expected bytes as {last, data}; expected events: 1 ok, 2 err, 3 overflow.
   logic [8:0] exp_bytes[$];
   int         exp_ev[$];

   serial_deframer #(.SYNC_BYTE(8'hA5), .MAX_LEN(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .overflow  (overflow),
      .in_sync   (in_sync)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pop_event(input int code, input string name);
      if (exp_ev.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: unexpected pulse, expected none at %0t", name, $time);
      end else begin
         check(name, 32'(code), 32'(exp_ev.pop_front()));
      end
   endtask

   // Monitor: sample mid-cycle, pop the scoreboard on accepts and on pulses.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (exp_bytes.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL out_byte: unexpected 0x%0h last=%0b, expected none at %0t",
                        out_data, out_last, $time);
            end else begin
               check("out_byte", 32'({out_last, out_data}), 32'(exp_bytes.pop_front()));
            end
         end
         if (overflow)  pop_event(3, "overflow");
         if (frame_ok)  pop_event(1, "frame_ok");
         if (frame_err) pop_event(2, "frame_err");
      end
   end

   // Send one byte LSB first with up to max_gap idle cycles before each bit.
   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int gap;
      for (int i = 0; i < 8; i++) begin
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         bit_in    = b[i];
         bit_valid = 1'b1;
         @(posedge clk);
         #1;
         bit_valid = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Good frame A5 02 11 22 33, preceded by a zero byte so the hunt starts clean.
   task automatic good_frame(input int max_gap);
      exp_bytes.push_back({1'b0, 8'h11});
      exp_bytes.push_back({1'b1, 8'h22});
      exp_ev.push_back(1);
      send_byte(8'h00, max_gap);
      send_byte(8'hA5, max_gap);
      check("in_sync_after_sync", 32'(in_sync), 32'd1);
      send_byte(8'h02, max_gap);
      send_byte(8'h11, max_gap);
      send_byte(8'h22, max_gap);
      send_byte(8'h33, max_gap);
      check("ok_timing", 32'(frame_ok), 32'd1);
      check("in_sync_after_check", 32'(in_sync), 32'd0);
      idle(1);
      check("ok_one_cycle", 32'(frame_ok), 32'd0);
      idle(3);
   endtask

   task automatic bad_len_frame(input logic [7:0] len);
      exp_ev.push_back(2);
      send_byte(8'h00, 0);
      send_byte(8'hA5, 0);
      send_byte(len, 0);
      check("len_err_timing", 32'(frame_err), 32'd1);
      check("len_err_in_sync", 32'(in_sync), 32'd0);
      idle(1);
      check("len_err_one_cycle", 32'(frame_err), 32'd0);
      idle(3);
   endtask

   initial begin
      rst_n     = 1'b0;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      out_ready = 1'b1;
      idle(3);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_last",  32'(out_last),  32'd0);
      check("rst_frame_ok",  32'(frame_ok),  32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_overflow",  32'(overflow),  32'd0);
      check("rst_in_sync",   32'(in_sync),   32'd0);
      rst_n = 1'b1;
      idle(2);

      // Contiguous good frame.
      good_frame(0);

      // Bad checksum: payload still delivered, frame rejected.
      exp_bytes.push_back({1'b0, 8'h11});
      exp_bytes.push_back({1'b1, 8'h22});
      exp_ev.push_back(2);
      send_byte(8'h00, 0);
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h34, 0);
      check("bad_sum_err", 32'(frame_err), 32'd1);
      check("bad_sum_no_ok", 32'(frame_ok), 32'd0);
      idle(3);

      // Illegal lengths, then a normal frame is still accepted.
      bad_len_frame(8'h00);
      bad_len_frame(8'h11);
      good_frame(0);

      // Stalled consumer: first byte held, two overflows, frame rejected.
      out_ready = 1'b0;
      exp_ev.push_back(3);
      exp_ev.push_back(3);
      exp_ev.push_back(2);
      send_byte(8'h00, 0);
      send_byte(8'hA5, 0);
      send_byte(8'h03, 0);
      send_byte(8'h01, 0);
      check("held_valid", 32'(out_valid), 32'd1);
      check("held_data", 32'(out_data), 32'h01);
      send_byte(8'h02, 0);
      send_byte(8'h03, 0);
      send_byte(8'h06, 0);
      check("ovf_frame_err", 32'(frame_err), 32'd1);
      check("held_data_after", 32'(out_data), 32'h01);
      idle(2);
      exp_bytes.push_back({1'b0, 8'h01});
      out_ready = 1'b1;
      idle(2);
      check("held_released", 32'(out_valid), 32'd0);

      // Gapped bit stream gives the same result.
      good_frame(5);
      good_frame(3);

      // Reset mid-payload with a byte held, then a clean frame.
      out_ready = 1'b0;
      send_byte(8'h00, 0);
      send_byte(8'hA5, 0);
      send_byte(8'h03, 0);
      send_byte(8'h01, 0);
      for (int i = 0; i < 4; i++) begin
         bit_in    = 1'b1;
         bit_valid = 1'b1;
         idle(1);
      end
      bit_valid = 1'b0;
      check("pre_rst_in_sync", 32'(in_sync), 32'd1);
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_data",  32'(out_data),  32'd0);
      check("mid_rst_out_last",  32'(out_last),  32'd0);
      check("mid_rst_in_sync",   32'(in_sync),   32'd0);
      check("mid_rst_pulses",    32'({frame_ok, frame_err, overflow}), 32'd0);
      out_ready = 1'b1;
      idle(2);
      good_frame(0);

      idle(10);
      check("bytes_drained", 32'(exp_bytes.size()), 32'd0);
      check("events_drained", 32'(exp_ev.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
